// File: rtl/camlink_pkg.sv
// Shared types and constants for the Camera Link test-pattern generator.
// Checker cell size is a power of two so a single x/y bit selects the cell parity.
package camlink_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_LINE,
    ST_HBLK,
    ST_VBLK
  } state_t;

  typedef enum logic [1:0] {
    PAT_HRAMP = 2'd0,
    PAT_VRAMP = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pat_mode_t;

  localparam int CELL_SIZE = 8;

  function automatic int cnt_width(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/camlink_pattern_gen_if.sv
// Camera Link-style video strobes plus pixel bus; the generator is the master.
// No backpressure: the slave must accept one pixel per pix_clk while dval is high.
interface camlink_pattern_gen_if #(
  parameter int BPP = 12
);
  logic           fval;
  logic           lval;
  logic           dval;
  logic [BPP-1:0] pix_data;

  modport master (output fval, lval, dval, pix_data);
  modport slave  (input  fval, lval, dval, pix_data);
endinterface

// File: rtl/cl_pattern_src.sv
// Combinational pixel value from (x, y, mode, solid); zero latency, no backpressure.
// Checkerboard logic exists only when CAMLINK_GEN_CHECKER_EN is defined, else mode 2 is a ramp.
module cl_pattern_src
  import camlink_pkg::*;
#(
  parameter int BPP = 12,
  parameter int XW  = 10,
  parameter int YW  = 9
) (
  input  logic [XW-1:0]  x,
  input  logic [YW-1:0]  y,
  input  pat_mode_t      mode,
  input  logic [BPP-1:0] solid_val,
  output logic [BPP-1:0] pix
);

`ifdef CAMLINK_GEN_CHECKER_EN
  logic cell_x;
  logic cell_y;
  assign cell_x = |(32'(x) & 32'(CELL_SIZE));
  assign cell_y = |(32'(y) & 32'(CELL_SIZE));
`endif

  always_comb begin
    pix = '0;
    case (mode)
      PAT_HRAMP: pix = BPP'(x);
      PAT_VRAMP: pix = BPP'(y);
`ifdef CAMLINK_GEN_CHECKER_EN
      PAT_CHECK: pix = (cell_x ^ cell_y) ? '1 : '0;
`else
      PAT_CHECK: pix = BPP'(x);
`endif
      PAT_SOLID: pix = solid_val;
      default:   pix = '0;
    endcase
  end

endmodule

// File: rtl/camlink_pattern_gen.sv
// Camera Link frame/line pattern generator; every output registered, trailing the FSM state by one cycle.
// No backpressure; CAMLINK_GEN_CHECKER_EN adds the checkerboard pattern (mode 2).
module camlink_pattern_gen
  import camlink_pkg::*;
#(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 512,
  parameter int BPP     = 12,
  parameter int FV_LEAD = 4,
  parameter int HBLANK  = 16,
  parameter int VBLANK  = 8
) (
  input  logic                  pix_clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [BPP-1:0]        solid_val,
  camlink_pattern_gen_if.master vid,
  output logic                  busy,
  output logic                  frame_done,
  output logic [7:0]            frame_cnt
);

  localparam int XW    = cnt_width(WIDTH);
  localparam int YW    = cnt_width(HEIGHT);
  localparam int CMAX  = (FV_LEAD > HBLANK) ? ((FV_LEAD > VBLANK) ? FV_LEAD : VBLANK)
                                            : ((HBLANK > VBLANK) ? HBLANK : VBLANK);
  localparam int CW    = cnt_width(CMAX);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  pat_mode_t      mode_q;
  logic [BPP-1:0] solid_q;
  logic [BPP-1:0] pix;

  cl_pattern_src #(.BPP(BPP), .XW(XW), .YW(YW)) u_src (
    .x         (x),
    .y         (y),
    .mode      (mode_q),
    .solid_val (solid_q),
    .pix       (pix)
  );

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      x            <= '0;
      y            <= '0;
      mode_q       <= PAT_HRAMP;
      solid_q      <= '0;
      vid.fval     <= 1'b0;
      vid.lval     <= 1'b0;
      vid.dval     <= 1'b0;
      vid.pix_data <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      // Outputs decode the state held during this cycle, so strobes, pixel and status stay aligned.
      vid.fval     <= (state == ST_LEAD) || (state == ST_LINE) || (state == ST_HBLK);
      vid.lval     <= (state == ST_LINE);
      vid.dval     <= (state == ST_LINE);
      vid.pix_data <= (state == ST_LINE) ? pix : '0;
      busy         <= (state == ST_LEAD) || (state == ST_LINE) || (state == ST_HBLK);
      frame_done   <= (state == ST_VBLK) && (cnt == '0);
      if ((state == ST_VBLK) && (cnt == '0)) frame_cnt <= frame_cnt + 8'd1;

      case (state)
        ST_IDLE: begin
          if (enable || start) begin
            state   <= ST_LEAD;
            cnt     <= '0;
            x       <= '0;
            y       <= '0;
            mode_q  <= pat_mode_t'(mode);
            solid_q <= solid_val;
          end
        end
        ST_LEAD: begin
          if (cnt == CW'(FV_LEAD - 1)) begin
            state <= ST_LINE;
            x     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_LINE: begin
          if (x == XW'(WIDTH - 1)) begin
            state <= ST_HBLK;
            cnt   <= '0;
          end else begin
            x <= x + 1'b1;
          end
        end
        ST_HBLK: begin
          if (cnt == CW'(HBLANK - 1)) begin
            cnt <= '0;
            if (y != YW'(HEIGHT - 1)) begin
              state <= ST_LINE;
              x     <= '0;
              y     <= y + 1'b1;
            end else begin
              state <= ST_VBLK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_VBLK: begin
          if (cnt == CW'(VBLANK - 1)) begin
            cnt <= '0;
            x   <= '0;
            y   <= '0;
            if (enable) begin
              state   <= ST_LEAD;
              mode_q  <= pat_mode_t'(mode);
              solid_q <= solid_val;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
